control_unit: RTL and testbench

Multi-cycle fetch/decode/execute/write-back sequencer that sits directly upstream of `datapath`.
- Owns the program counter, instruction register and latched ALU flags.
- Fetches 16-bit instructions from a synchronous-read instruction memory.
- Drives every `datapath` control input: register-file addresses and write, ALU select, immediate path, memory write/select.

---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/instr_decoder.sv | 45 ++++
 rtl/control_unit.sv | 114 +++++++++++
 tb/tb_control_unit.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM states and control bundle
// for the multi-cycle control unit.
package cpu_pkg;

  localparam logic [4:0] OP_RMAX = 5'b01010;
  localparam logic [4:0] OP_MOVI = 5'b10110;
  localparam logic [4:0] OP_LD   = 5'b11000;
  localparam logic [4:0] OP_ST   = 5'b11001;
  localparam logic [4:0] OP_JMP  = 5'b11100;
  localparam logic [4:0] OP_BZ   = 5'b11101;
  localparam logic [4:0] OP_BP   = 5'b11110;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [3:0] ALU_PASS_B = 4'b1011;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 11;
  localparam int RD_HI  = 10;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 5;
  localparam int RT_HI  = 4;
  localparam int RT_LO  = 2;
  localparam int IMM_HI = 7;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALT
  } state_t;

  typedef struct packed {
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [7:0] imm8;
    logic [3:0] alu_sel;
    logic       imm_sel;
    logic       mem_sel;
    logic       rf_we;
    logic       mem_we;
    logic       alu_cls;
    logic       jmp;
    logic       bz;
    logic       bp;
    logic       halt;
  } ctrl_t;

  function automatic logic is_rtype(
    input logic [4:0] op
  );
    return op <= OP_RMAX;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of one 16-bit
// instruction into the control bundle.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output ctrl_t       ctrl
);

  logic [4:0] op;

  assign op = ir[OP_HI:OP_LO];

  always_comb begin
    ctrl      = '0;
    ctrl.rd   = ir[RD_HI:RD_LO];
    ctrl.rs   = ir[RS_HI:RS_LO];
    ctrl.rt   = ir[RT_HI:RT_LO];
    ctrl.imm8 = ir[IMM_HI:0];
    unique case (1'b1)
      is_rtype(op): begin
        ctrl.alu_sel = op[3:0];
        ctrl.rf_we   = 1'b1;
        ctrl.alu_cls = 1'b1;
      end
      (op == OP_MOVI): begin
        ctrl.alu_sel = ALU_PASS_B;
        ctrl.imm_sel = 1'b1;
        ctrl.rf_we   = 1'b1;
        ctrl.alu_cls = 1'b1;
      end
      (op == OP_LD): begin
        ctrl.mem_sel = 1'b1;
        ctrl.rf_we   = 1'b1;
      end
      (op == OP_ST):   ctrl.mem_we = 1'b1;
      (op == OP_JMP):  ctrl.jmp    = 1'b1;
      (op == OP_BZ):   ctrl.bz     = 1'b1;
      (op == OP_BP):   ctrl.bp     = 1'b1;
      (op == OP_HALT): ctrl.halt   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute/write-back sequencer
// driving the datapath control inputs.
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  output logic [PC_WIDTH-1:0]   pc,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic                  zero_flag,
  input  logic                  pos_flag,
  output logic                  rf_write,
  output logic [2:0]            rs_addr,
  output logic [2:0]            rt_addr,
  output logic [2:0]            rd_addr,
  output logic [DATA_WIDTH-1:0] imm_data,
  output logic [3:0]            alu_sel,
  output logic                  imm_sel,
  output logic                  mem_write,
  output logic                  mem_sel,
  output logic                  halted
);

  state_t        state_q;
  state_t        state_d;
  logic [15:0]   ir_q;
  logic [15:0]   dec_in;
  ctrl_t         ctrl;
  logic          zf_q;
  logic          pf_q;
  logic          take;
  logic          run;

  // In DECODE the word is still on the bus;
  // afterwards ir_q is the source of truth.
  assign dec_in = (state_q == DECODE) ?
                  instr_in[15:0] : ir_q;

  instr_decoder u_dec (
    .ir   (dec_in),
    .ctrl (ctrl)
  );

  assign take = ctrl.jmp
              | (ctrl.bz & zf_q)
              | (ctrl.bp & pf_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:     state_d = DECODE;
      DECODE:    state_d = EXECUTE;
      EXECUTE:   state_d = ctrl.halt ?
                           HALT : WRITEBACK;
      WRITEBACK: state_d = FETCH;
      HALT:      state_d = HALT;
      default:   state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= FETCH;
      pc       <= '0;
      ir_q     <= '0;
      zf_q     <= 1'b0;
      pf_q     <= 1'b0;
      rs_addr  <= '0;
      rt_addr  <= '0;
      rd_addr  <= '0;
      imm_data <= '0;
      alu_sel  <= '0;
      imm_sel  <= 1'b0;
      mem_sel  <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        ir_q     <= instr_in[15:0];
        pc       <= pc + PC_WIDTH'(1);
        rs_addr  <= ctrl.rs;
        rt_addr  <= ctrl.rt;
        rd_addr  <= ctrl.rd;
        imm_data <= DATA_WIDTH'(ctrl.imm8);
        alu_sel  <= ctrl.alu_sel;
        imm_sel  <= ctrl.imm_sel;
        mem_sel  <= ctrl.mem_sel;
      end
      if (state_q == EXECUTE) begin
        if (ctrl.alu_cls) begin
          zf_q <= zero_flag;
          pf_q <= pos_flag;
        end
        if (take) pc <= PC_WIDTH'(ctrl.imm8);
      end
    end
  end

  // Strobes drop while frozen or in reset and
  // come back for one cycle once the FSM moves.
  assign run = reset & enable;

  assign rf_write  = run
                   & (state_q == WRITEBACK)
                   & ctrl.rf_we;
  assign mem_write = run
                   & (state_q == EXECUTE)
                   & ctrl.mem_we;
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed plus random program checks of the
// control unit against an instruction-level model.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  pc;
  logic [15:0] instr_in = '0;
  logic        zero_flag = 1'b0;
  logic        pos_flag = 1'b0;
  logic        rf_write;
  logic [2:0]  rs_addr;
  logic [2:0]  rt_addr;
  logic [2:0]  rd_addr;
  logic [15:0] imm_data;
  logic [3:0]  alu_sel;
  logic        imm_sel;
  logic        mem_write;
  logic        mem_sel;
  logic        halted;

  control_unit #(
    .PC_WIDTH   (8),
    .DATA_WIDTH (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .pc        (pc),
    .instr_in  (instr_in),
    .zero_flag (zero_flag),
    .pos_flag  (pos_flag),
    .rf_write  (rf_write),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rd_addr   (rd_addr),
    .imm_data  (imm_data),
    .alu_sel   (alu_sel),
    .imm_sel   (imm_sel),
    .mem_write (mem_write),
    .mem_sel   (mem_sel),
    .halted    (halted)
  );

  always #5 clock = ~clock;

  logic [15:0] imem [256];

  always @(posedge clock) instr_in <= imem[pc];

  int errors = 0;
  int checks = 0;

  logic [7:0] m_pc;
  logic       m_zf;
  logic       m_pf;
  logic [2:0] p_rd;
  logic [7:0] p_imm;
  logic       p_isel;
  logic       p_msel;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = '0;
    m_zf   = 1'b0;
    m_pf   = 1'b0;
    p_rd   = '0;
    p_imm  = '0;
    p_isel = 1'b0;
    p_msel = 1'b0;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    enable = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    check("rst_pc", 32'(pc), 0);
    check("rst_halt", 32'(halted), 0);
    check("rst_rf", 32'(rf_write), 0);
    check("rst_mw", 32'(mem_write), 0);
    check("rst_rd", 32'(rd_addr), 0);
    check("rst_imm", 32'(imm_data), 0);
    check("rst_alu", 32'(alu_sel), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // One instruction from FETCH onward; optional
  // freeze of hold_len cycles in phase hold_ph.
  task automatic run_instr(
    input logic [15:0] ins,
    input logic        zf,
    input logic        pf,
    input int          hold_ph,
    input int          hold_len
  );
    logic [4:0] op;
    logic [7:0] pc1;
    logic [7:0] nxt;
    logic [3:0] e_alu;
    logic rty, movi, ld, st, jmp;
    logic bz, bp, hlt, wr;
    int nph, cyc, n_rf, n_mw, e_cyc;
    op   = ins[15:11];
    rty  = (op <= 5'd10);
    movi = (op == 5'b10110);
    ld   = (op == 5'b11000);
    st   = (op == 5'b11001);
    jmp  = (op == 5'b11100);
    bz   = (op == 5'b11101);
    bp   = (op == 5'b11110);
    hlt  = (op == 5'b11111);
    wr   = rty | movi | ld;
    e_alu = rty ? op[3:0] : 4'b1011;
    pc1  = m_pc + 8'd1;
    nxt  = pc1;
    if (jmp || (bz && m_zf) || (bp && m_pf))
      nxt = ins[7:0];
    nph  = hlt ? 3 : 4;
    cyc  = 0;
    n_rf = 0;
    n_mw = 0;
    imem[m_pc] = ins;
    zero_flag = zf;
    pos_flag  = pf;
    for (int ph = 0; ph < nph; ph++) begin
      if (ph == hold_ph) begin
        for (int h = 0; h < hold_len; h++) begin
          enable = 1'b0;
          @(negedge clock);
          cyc++;
          check("hold_rf", 32'(rf_write), 0);
          check("hold_mw", 32'(mem_write), 0);
          @(posedge clock);
          #1;
        end
      end
      enable = 1'b1;
      @(negedge clock);
      cyc++;
      n_rf += int'(rf_write);
      n_mw += int'(mem_write);
      if (ph == 0) begin
        check("f_pc", 32'(pc), 32'(m_pc));
        check("f_halt", 32'(halted), 0);
        check("f_rd", 32'(rd_addr), 32'(p_rd));
        check("f_imm", 32'(imm_data),
              32'(p_imm));
        check("f_isel", 32'(imm_sel),
              32'(p_isel));
        check("f_msel", 32'(mem_sel),
              32'(p_msel));
      end else if (ph == 1) begin
        check("d_pc", 32'(pc), 32'(m_pc));
      end else begin
        check(ph == 2 ? "e_pc" : "w_pc", 32'(pc),
              32'(ph == 2 ? pc1 : nxt));
        check("x_rd", 32'(rd_addr),
              32'(ins[10:8]));
        check("x_rs", 32'(rs_addr),
              32'(ins[7:5]));
        check("x_rt", 32'(rt_addr),
              32'(ins[4:2]));
        check("x_imm", 32'(imm_data),
              32'(ins[7:0]));
        check("x_isel", 32'(imm_sel),
              32'(movi));
        check("x_msel", 32'(mem_sel),
              32'(ld));
        if (rty || movi)
          check("x_alu", 32'(alu_sel),
                32'(e_alu));
      end
      @(posedge clock);
      #1;
    end
    e_cyc = nph;
    if (hold_ph < nph) e_cyc += hold_len;
    check("rf_cnt", 32'(n_rf), 32'(wr));
    check("mw_cnt", 32'(n_mw), 32'(st));
    check("cycles", 32'(cyc), 32'(e_cyc));
    if (rty || movi) begin
      m_zf = zf;
      m_pf = pf;
    end
    m_pc   = nxt;
    p_rd   = ins[10:8];
    p_imm  = ins[7:0];
    p_isel = movi;
    p_msel = ld;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [4:0] op;
    int k;
    k = $urandom_range(0, 7);
    case (k)
      0: op = 5'($urandom_range(0, 10));
      1: op = 5'b10110;
      2: op = 5'b11000;
      3: op = 5'b11001;
      4: op = 5'b11100;
      5: op = 5'b11101;
      6: op = 5'b11110;
      default: begin
        op = 5'($urandom_range(11, 21));
      end
    endcase
    return {op, 11'($urandom)};
  endfunction

  initial begin
    logic [7:0]  hpc;
    logic [15:0] w;
    int hp, hl;
    for (int i = 0; i < 256; i++)
      imem[i] = '0;
    model_reset();
    do_reset();

    // MOVI R7, #8
    run_instr(16'b10110_111_00001000, 0, 0, 9, 0);

    // SUB R1,R2,R2 then BZ #20, taken
    run_instr({5'b00001, 3'd1, 3'd2, 3'd2, 2'b00},
              1'b1, 1'b0, 9, 0);
    run_instr({5'b11101, 3'd0, 8'h20},
              1'b0, 1'b0, 9, 0);
    check("bz_taken", 32'(pc), 32'h20);

    do_reset();
    run_instr({5'b00001, 3'd1, 3'd2, 3'd2, 2'b00},
              1'b0, 1'b1, 9, 0);
    run_instr({5'b11101, 3'd0, 8'h20},
              1'b1, 1'b1, 9, 0);
    check("bz_fall", 32'(pc), 32'h02);

    // ST rs=3 rt=4
    run_instr({5'b11001, 3'd0, 3'd3, 3'd4, 2'b00},
              1'b0, 1'b0, 9, 0);

    // ADD frozen 5 cycles in WRITEBACK
    run_instr({5'b00000, 3'd5, 3'd1, 3'd2, 2'b00},
              1'b0, 1'b0, 3, 5);

    // Reset during EXECUTE of a store
    w = {5'b11001, 3'd0, 3'd3, 3'd4, 2'b00};
    imem[m_pc] = w;
    enable = 1'b1;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    @(negedge clock);
    check("rst_ex_mw", 32'(mem_write), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    check("rst_ex_pc", 32'(pc), 0);
    check("rst_ex_rs", 32'(rs_addr), 0);
    check("rst_ex_mw2", 32'(mem_write), 0);
    model_reset();

    // pc wrap 8'hFF -> 8'h00
    run_instr({5'b11100, 3'd0, 8'hFF},
              1'b0, 1'b0, 9, 0);
    run_instr({5'b10001, 11'h0},
              1'b0, 1'b0, 9, 0);
    check("pc_wrap", 32'(pc), 0);

    for (int n = 0; n < 60; n++) begin
      hp = 9;
      hl = 0;
      if ($urandom_range(0, 3) == 0) begin
        hp = $urandom_range(0, 3);
        hl = $urandom_range(1, 3);
      end
      run_instr(rand_instr(),
                1'($urandom), 1'($urandom),
                hp, hl);
    end

    // NOP then HALT, frozen until reset
    run_instr({5'b10001, 11'h7FF},
              1'b1, 1'b1, 9, 0);
    run_instr({5'b11111, 11'h0},
              1'b0, 1'b0, 9, 0);
    hpc = m_pc;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      check("h_halt", 32'(halted), 1);
      check("h_pc", 32'(pc), 32'(hpc));
      check("h_rf", 32'(rf_write), 0);
      check("h_mw", 32'(mem_write), 0);
    end
    @(posedge clock);
    #1;
    do_reset();
    check("post_halt", 32'(halted), 0);
    run_instr({5'b10110, 3'd2, 8'h5A},
              1'b0, 1'b0, 9, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
